// File: rtl/round_key_store_if.sv
// round_key_store_if: key-capture and key-replay stream bundle for round_key_store.
interface round_key_store_if #(parameter int KEY_S = 128, parameter int AW = 4);
  logic load_start;
  logic w_e;
  logic [AW-1:0] round_key_addr;
  logic [KEY_S-1:0] round_key;
  logic keys_ready;
  logic stream_start;
  logic stream_dir;
  logic [KEY_S-1:0] out_key;
  logic [AW-1:0] out_addr;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic busy;
  logic err;
  modport master (
    output load_start, w_e, round_key_addr, round_key, stream_start, stream_dir, out_ready,
    input keys_ready, out_key, out_addr, out_valid, out_last, busy, err
  );
  modport slave (
    input load_start, w_e, round_key_addr, round_key, stream_start, stream_dir, out_ready,
    output keys_ready, out_key, out_addr, out_valid, out_last, busy, err
  );
endinterface

// File: rtl/round_key_store.sv
// round_key_store: buffers NR+1 round keys and replays them forward or reverse as a valid/ready stream.
// Define ROUND_KEY_STORE_PARITY_EN to store an even-parity bit per key and flag mismatches on replay.
module round_key_store #(
  parameter int KEY_S = 128,
  parameter int NR = 10,
  parameter int AW = 4
) (
  input logic clk,
  input logic reset,
  round_key_store_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOADING, READY, STREAM} state_t;
  localparam logic [AW-1:0] LAST = AW'(NR);
  state_t state, state_n;
  logic [KEY_S-1:0] mem [0:NR];
  logic [NR:0] mask, mask_n;
  logic [KEY_S-1:0] out_key;
  logic [AW-1:0] out_addr, out_addr_n;
  logic keys_ready, keys_ready_n, out_valid, out_valid_n, out_last, out_last_n;
  logic busy, err, err_n, dir, dir_n, we, key_ld, addr_ok;
`ifdef ROUND_KEY_STORE_PARITY_EN
  logic par [0:NR];
`endif
  assign addr_ok = bus.round_key_addr <= LAST;
  assign bus.keys_ready = keys_ready;
  assign bus.out_key = out_key;
  assign bus.out_addr = out_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_last = out_last;
  assign bus.busy = busy;
  assign bus.err = err;
  always_comb begin
    state_n = state;
    mask_n = mask;
    keys_ready_n = keys_ready;
    out_valid_n = out_valid;
    out_last_n = out_last;
    out_addr_n = out_addr;
    dir_n = dir;
    err_n = err;
    we = 1'b0;
    key_ld = 1'b0;
    if (bus.load_start) begin
      state_n = LOADING;
      mask_n = '0;
      keys_ready_n = 1'b0;
      out_valid_n = 1'b0;
      out_last_n = 1'b0;
    end else begin
      if (bus.w_e) begin
        we = (state == LOADING) && addr_ok;
        err_n = err | !we;
        if (we) mask_n[bus.round_key_addr] = 1'b1;
      end
      if (state == LOADING && &mask) begin
        state_n = READY;
        keys_ready_n = 1'b1;
      end
      if (bus.stream_start) begin
        if (state == READY) begin
          state_n = STREAM;
          dir_n = bus.stream_dir;
          out_valid_n = 1'b1;
          out_addr_n = bus.stream_dir ? LAST : '0;
          key_ld = 1'b1;
        end else err_n = 1'b1;
      end
      if (state == STREAM && out_valid && bus.out_ready) begin
        if (out_last) begin
          out_valid_n = 1'b0;
          state_n = READY;
        end else begin
          out_addr_n = dir ? out_addr - 1'b1 : out_addr + 1'b1;
          key_ld = 1'b1;
        end
      end
      out_last_n = out_valid_n && (dir_n ? out_addr_n == '0 : out_addr_n == LAST);
    end
`ifdef ROUND_KEY_STORE_PARITY_EN
    if (key_ld && ((^mem[out_addr_n]) != par[out_addr_n])) err_n = 1'b1;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mask <= '0;
      keys_ready <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      out_key <= '0;
      out_addr <= '0;
      dir <= 1'b0;
    end else begin
      state <= state_n;
      mask <= mask_n;
      keys_ready <= keys_ready_n;
      out_valid <= out_valid_n;
      out_last <= out_last_n;
      busy <= (state_n == LOADING) || (state_n == STREAM);
      err <= err_n;
      out_addr <= out_addr_n;
      dir <= dir_n;
      if (key_ld) out_key <= mem[out_addr_n];
    end
  end
  // Key storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[bus.round_key_addr] <= bus.round_key;
`ifdef ROUND_KEY_STORE_PARITY_EN
    if (we) par[bus.round_key_addr] <= ^bus.round_key;
`endif
  end
endmodule
